// File: rtl/mac_pkg.sv
// Shared types and sizing constants for the MAC partial-sum requantizer.
package mac_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    REQ,
    HOLD
  } state_e;

  localparam int NumMac     = 4;
  localparam int AccWidth   = 16;
  localparam int PsumWidth  = 24;
  localparam int OutWidth   = 8;
  localparam int MaxTiles   = 16;
  localparam int ShiftWidth = 5;

  function automatic int satMax(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int satMin(input int w);
    return -(1 << (w - 1));
  endfunction

  localparam int OutMax = satMax(OutWidth);
  localparam int OutMin = satMin(OutWidth);

  // A full group of MaxTiles beats can never overflow the partial sum when this holds.
  localparam bit PsumSizingOk = (PsumWidth >= AccWidth + $clog2(MaxTiles));

endpackage

// File: rtl/requant_lane.sv
// Single-lane combinational requantizer: arithmetic shift, round-half-up, saturate.
// Optional ReLU on the saturated result when MAC_PSUM_RELU_EN is defined.
module requant_lane
  import mac_pkg::*;
#(
  parameter int PSUM_WIDTH  = PsumWidth,
  parameter int OUT_WIDTH   = OutWidth,
  parameter int SHIFT_WIDTH = ShiftWidth
) (
  input  logic signed [PSUM_WIDTH-1:0]  psum_i,
  input  logic        [SHIFT_WIDTH-1:0] shift_i,
  output logic        [OUT_WIDTH-1:0]   lane_o
);

  localparam logic signed [PSUM_WIDTH:0] SatMax = (PSUM_WIDTH+1)'(satMax(OUT_WIDTH));
  localparam logic signed [PSUM_WIDTH:0] SatMin = (PSUM_WIDTH+1)'(satMin(OUT_WIDTH));

  int                          sh;
  logic signed [PSUM_WIDTH:0]  ext;
  logic signed [PSUM_WIDTH:0]  rnd;
  logic signed [PSUM_WIDTH:0]  shifted;
  logic        [OUT_WIDTH-1:0] sat;

  // One extra bit of headroom keeps psum plus the rounding bias from wrapping.
  always_comb begin
    sh      = (int'(shift_i) > PSUM_WIDTH - 1) ? PSUM_WIDTH - 1 : int'(shift_i);
    ext     = {psum_i[PSUM_WIDTH-1], psum_i};
    rnd     = (sh > 0) ? ((PSUM_WIDTH+1)'(1) <<< (sh - 1)) : '0;
    shifted = (ext + rnd) >>> sh;
    if (shifted > SatMax) begin
      sat = SatMax[OUT_WIDTH-1:0];
    end else if (shifted < SatMin) begin
      sat = SatMin[OUT_WIDTH-1:0];
    end else begin
      sat = shifted[OUT_WIDTH-1:0];
    end
`ifdef MAC_PSUM_RELU_EN
    lane_o = sat[OUT_WIDTH-1] ? '0 : sat;
`else
    lane_o = sat;
`endif
  end

endmodule

// File: rtl/mac_psum_requant.sv
// Accumulates MAC partial sums over a tile group, then requantizes and hands off one vector.
// Build option: MAC_PSUM_RELU_EN clamps negative output lanes to zero.
module mac_psum_requant
  import mac_pkg::*;
#(
  parameter int NUM_MAC     = NumMac,
  parameter int ACC_WIDTH   = AccWidth,
  parameter int PSUM_WIDTH  = PsumWidth,
  parameter int OUT_WIDTH   = OutWidth,
  parameter int MAX_TILES   = MaxTiles,
  parameter int SHIFT_WIDTH = ShiftWidth
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [NUM_MAC*ACC_WIDTH-1:0]   in_acc_i,
  input  logic                           in_last_i,
  input  logic [SHIFT_WIDTH-1:0]         cfg_shift_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [NUM_MAC*OUT_WIDTH-1:0]   out_data_o,
  output logic                           out_forced_o
);

  localparam int CntWidth = $clog2(MAX_TILES) + 1;

  state_e                         state_q, state_d;
  logic signed [PSUM_WIDTH-1:0]   psum_q [NUM_MAC];
  logic signed [PSUM_WIDTH-1:0]   psum_d [NUM_MAC];
  logic        [CntWidth-1:0]     tileCnt_q, tileCnt_d;
  logic        [SHIFT_WIDTH-1:0]  shift_q, shift_d;
  logic                           forced_q, forced_d;
  logic                           outValid_q, outValid_d;
  logic                           outForced_q, outForced_d;
  logic [NUM_MAC*OUT_WIDTH-1:0]   outData_q, outData_d;
  logic [NUM_MAC*OUT_WIDTH-1:0]   laneOut;
  logic signed [PSUM_WIDTH-1:0]   accExt;
  logic                           closeGroup;

  for (genvar g = 0; g < NUM_MAC; g++) begin : gLane
    requant_lane #(
      .PSUM_WIDTH (PSUM_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH)
    ) uLane (
      .psum_i (psum_q[g]),
      .shift_i(shift_q),
      .lane_o (laneOut[g*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  assign in_ready_o   = (state_q == ACCUM);
  assign out_valid_o  = outValid_q;
  assign out_data_o   = outData_q;
  assign out_forced_o = outForced_q;
  assign closeGroup   = in_last_i || (tileCnt_q == CntWidth'(MAX_TILES - 1));

  always_comb begin
    state_d     = state_q;
    psum_d      = psum_q;
    tileCnt_d   = tileCnt_q;
    shift_d     = shift_q;
    forced_d    = forced_q;
    outValid_d  = outValid_q;
    outForced_d = outForced_q;
    outData_d   = outData_q;
    accExt      = '0;
    unique case (state_q)
      ACCUM: begin
        if (in_valid_i) begin
          // The first beat of a group overwrites rather than adds, so no clear cycle is needed.
          for (int i = 0; i < NUM_MAC; i++) begin
            accExt    = {{(PSUM_WIDTH-ACC_WIDTH){in_acc_i[i*ACC_WIDTH + ACC_WIDTH - 1]}},
                         in_acc_i[i*ACC_WIDTH +: ACC_WIDTH]};
            psum_d[i] = ((tileCnt_q == '0) ? '0 : psum_q[i]) + accExt;
          end
          tileCnt_d = tileCnt_q + CntWidth'(1);
          if (closeGroup) begin
            shift_d  = cfg_shift_i;
            forced_d = !in_last_i;
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        outData_d   = laneOut;
        outValid_d  = 1'b1;
        outForced_d = forced_q;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready_i) begin
          outValid_d = 1'b0;
          for (int i = 0; i < NUM_MAC; i++) psum_d[i] = '0;
          tileCnt_d  = '0;
          state_d    = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ACCUM;
      for (int i = 0; i < NUM_MAC; i++) psum_q[i] <= '0;
      tileCnt_q   <= '0;
      shift_q     <= '0;
      forced_q    <= 1'b0;
      outValid_q  <= 1'b0;
      outForced_q <= 1'b0;
      outData_q   <= '0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < NUM_MAC; i++) psum_q[i] <= psum_d[i];
      tileCnt_q   <= tileCnt_d;
      shift_q     <= shift_d;
      forced_q    <= forced_d;
      outValid_q  <= outValid_d;
      outForced_q <= outForced_d;
      outData_q   <= outData_d;
    end
  end

endmodule

// File: tb/tb_mac_psum_requant.sv
// Directed self-checking bench for mac_psum_requant with hand-computed expectations.
module tb_mac_psum_requant;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_acc;
  logic        in_last;
  logic [4:0]  cfg_shift;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_forced;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  mac_psum_requant dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_acc_i    (in_acc),
    .in_last_i   (in_last),
    .cfg_shift_i (cfg_shift),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_forced_o(out_forced)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int ex(input int v);
`ifdef MAC_PSUM_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic int laneOf(input int i);
    logic [7:0] v;
    v = out_data[i*8 +: 8];
    return int'($signed(v));
  endfunction

  task automatic checkLanes(input string tag, input int e0, input int e1, input int e2, input int e3);
    checkOutput({tag, "_lane0"}, laneOf(0), ex(e0));
    checkOutput({tag, "_lane1"}, laneOf(1), ex(e1));
    checkOutput({tag, "_lane2"}, laneOf(2), ex(e2));
    checkOutput({tag, "_lane3"}, laneOf(3), ex(e3));
  endtask

  // Present one beat and hold it until the edge where in_ready is seen high.
  task automatic applyStimulus(input logic [63:0] acc, input logic last, input logic [4:0] shift);
    bit accepted;
    accepted  = 0;
    in_acc    = acc;
    in_last   = last;
    cfg_shift = shift;
    in_valid  = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      if (in_ready) accepted = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!accepted) checkOutput("beat_accept_timeout", 0, 1);
  endtask

  task automatic waitOut(input string tag);
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    checkOutput({tag, "_out_valid"}, int'(out_valid), 1);
  endtask

  task automatic popOut();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_acc    = '0;
    in_last   = 1'b0;
    cfg_shift = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_out_data", int'(out_data), 0);
    checkOutput("reset_out_forced", int'(out_forced), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single beat with saturation, latency and backpressure.
    applyStimulus(pack4(10, -10, 300, -300), 1'b1, 5'd0);
    checkOutput("single_valid_after_accept", int'(out_valid), 0);
    checkOutput("single_in_ready_req", int'(in_ready), 0);
    @(posedge clk); #1;
    checkOutput("single_valid_next_edge", int'(out_valid), 1);
    checkLanes("single", 10, -10, 127, -128);
    checkOutput("single_forced", int'(out_forced), 0);
    in_acc    = pack4(99, 0, 0, 0);
    in_last   = 1'b1;
    cfg_shift = 5'd0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_in_ready", int'(in_ready), 0);
      checkOutput("bp_out_valid", int'(out_valid), 1);
      checkOutput("bp_lane2_stable", laneOf(2), ex(127));
      @(posedge clk); #1;
    end
    popOut();
    checkOutput("bp_release_in_ready", int'(in_ready), 1);
    checkOutput("bp_release_out_valid", int'(out_valid), 0);
    applyStimulus(pack4(99, 0, 0, 0), 1'b1, 5'd0);
    waitOut("bp_next");
    checkLanes("bp_next", 99, 0, 0, 0);
    popOut();

    // Three beats; the shift seen on early beats must be ignored.
    applyStimulus(pack4(100, -1, 40, 0), 1'b0, 5'd7);
    applyStimulus(pack4(100, -1, 40, 0), 1'b0, 5'd7);
    applyStimulus(pack4(100, -1, 40, 0), 1'b1, 5'd2);
    waitOut("three");
    checkLanes("three", 75, -1, 30, 0);
    checkOutput("three_forced", int'(out_forced), 0);
    popOut();

    // Round-half-up on negative and positive ties.
    applyStimulus(pack4(-6, 0, 0, 0), 1'b1, 5'd2);
    waitOut("round_a");
    checkLanes("round_a", -1, 0, 0, 0);
    popOut();
    applyStimulus(pack4(0, 5, -5, 0), 1'b1, 5'd1);
    waitOut("round_b");
    checkLanes("round_b", 0, 3, -2, 0);
    popOut();

    // Oversized shift clamps to PSUM_WIDTH-1 and rounds everything here to zero.
    applyStimulus(pack4(0, -1, 32767, -32768), 1'b1, 5'd31);
    waitOut("bigshift");
    checkLanes("bigshift", 0, 0, 0, 0);
    popOut();

    // Force-close after MAX_TILES beats without in_last.
    for (int i = 0; i < 15; i++) applyStimulus(pack4(1, 0, 0, 0), 1'b0, 5'd0);
    checkOutput("force_ready_after_15", int'(in_ready), 1);
    applyStimulus(pack4(1, 0, 0, 0), 1'b0, 5'd0);
    waitOut("force");
    checkLanes("force", 16, 0, 0, 0);
    checkOutput("force_forced", int'(out_forced), 1);
    popOut();

    // Reset in the middle of a group discards the partial sum.
    applyStimulus(pack4(50, 0, 0, 0), 1'b0, 5'd0);
    applyStimulus(pack4(50, 0, 0, 0), 1'b0, 5'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checkOutput("midreset_in_ready", int'(in_ready), 1);
    checkOutput("midreset_out_valid", int'(out_valid), 0);
    applyStimulus(pack4(7, 0, 0, 0), 1'b1, 5'd0);
    waitOut("midreset");
    checkLanes("midreset", 7, 0, 0, 0);
    checkOutput("midreset_forced", int'(out_forced), 0);
    popOut();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
